fetch_pc_ctrl: RTL and testbench
================================

# fetch_pc_ctrl

Fetch-stage sequencer that owns the program counter and drives the instruction-memory request handshake. Each cycle it selects the next PC from sequential (PC+4), jump (ID) and branch (EX) sources, holds the PC under hazard stalls, and discards wrong-path fetches after a redirect. It captures returned instructions into the IF/ID boundary, using a one-entry hold buffer while the pipeline is stalled.

## Interface
- RESET_VEC, 32'h00000000, PC loaded during reset
- TRAP_VEC, 32'h00000080, PC loaded on misaligned redirect (macro builds only)
- CLK  in  1  rising-edge clock
- RST_N  in  1  synchronous, active-low reset
- stall  in  1  hazard-unit hold of IF/ID
- br_taken  in  1  EX-stage branch taken
- br_target  in  32  branch target
- jmp_valid  in  1  ID-stage jump
- jmp_target  in  32  jump target
- imem_req  out  1  instruction-memory request
- imem_addr  out  32  request address (equals internal PC)
- imem_ack  in  1  memory accepted request; data valid this cycle
- imem_rdata  in  32  instruction word
- instr  out  32  registered instruction to IF/ID
- instr_pc  out  32  PC of `instr`
- if_valid  out  1  `instr` is valid
- flush_ifid  out  1  combinational `br_taken | jmp_valid`
- misalign_exc  out  1  one-cycle misaligned-redirect pulse

## Operation
- Reset (RST_N=0 at an edge):
  - PC=RESET_VEC; state=BOOT.
  - instr, instr_pc and if_valid clear to 0; misalign_exc=0.
  - imem_req=0 and imem_addr=RESET_VEC.
- Redirect target: br_target if br_taken, else jmp_target if jmp_valid. Branch beats jump.
- States:
  - BOOT: imem_req=0; go to FETCH on the next edge.
  - FETCH: imem_req=1, imem_addr=PC. Events at the clock edge:
    - Redirect with ack: PC<=target, if_valid<=0, stay in FETCH.
    - Redirect without ack: redir_pc<=target, if_valid<=0, go to DRAIN.
    - Ack, no redirect, stall=0: instr<=rdata, instr_pc<=PC, if_valid<=1, PC<=PC+4.
    - Ack, stall=1: hold_buf<=rdata, hold_pc<=PC, PC<=PC+4, go to HOLD. instr and if_valid are unchanged.
    - No ack, no redirect: if_valid<=0 if stall=0, otherwise it is retained.
  - DRAIN: imem_req=1 and imem_addr stays at the stale PC until ack.
    - Ack: discard the data, PC<=redir_pc, go to FETCH.
    - A new redirect in DRAIN overwrites redir_pc.
    - if_valid<=0.
  - HOLD: imem_req=0.
    - stall=0: instr<=hold_buf, instr_pc<=hold_pc, if_valid<=1, go to FETCH.
    - Redirect: discard the buffer, PC<=target, if_valid<=0, go to FETCH.
- Priority: redirect > stall > sequential.
- Once imem_req is asserted, it and imem_addr stay stable until ack. Neither stall nor redirect may drop a request.
- Arithmetic: PC+4 is modulo 2^32, so 32'hFFFFFFFC wraps to 32'h00000000.

## Timing
- imem_req, imem_addr and flush_ifid are combinational from state, PC and inputs. All other outputs are registered.
- First imem_req: the second cycle after RST_N is sampled high (one BOOT cycle).
- Zero-wait memory (ack in the request cycle): one instruction per cycle. if_valid rises one edge after ack.
- Redirect penalty with zero-wait memory: the target instruction appears at `instr` two edges after the redirect cycle.
- Reset asserted mid-request: the request is abandoned immediately. imem_req drops on the same cycle because state is BOOT.

## Configuration
- FETCH_MISALIGN_TRAP_EN defined:
  - A selected redirect target with bits [1:0]≠0 loads PC (or redir_pc) with TRAP_VEC.
  - misalign_exc pulses high for exactly one cycle (registered) after that edge.
- Not defined:
  - Target bits [1:0] are forced to 2'b00.
  - misalign_exc is tied to 0; the port is always present.

## Test plan
- **Reset and sequential fetch.** Release reset with ack tied high and rdata=PC.
  - Required: imem_addr sequence 0,4,8,….
  - Required: instr_pc equals instr each cycle and if_valid stays high.
- **Stall during ack.** Assert stall in the cycle addr=8 is acked.
  - Required: HOLD entered, imem_req=0, instr retains word 4.
  - After stall drops: instr=8 on the next edge, then fetch resumes at 12.
- **Branch beats jump.** In the same cycle assert br_taken (target 0x100) and jmp_valid (target 0x200).
  - Required: flush_ifid=1 and the next imem_addr=0x100.
- **Redirect during wait state.** Hold ack low at addr 0x20 and pulse br_taken with target 0x40.
  - Required: imem_addr stays 0x20 until ack, the data is discarded (if_valid=0), and the next addr is 0x40.
- **PC wrap.** Jump to 0xFFFFFFFC.
  - Required: the next sequential addr is 0x00000000.
- **Misaligned redirect.** Jump target 0x102.
  - Macro defined: addr becomes 0x80 and misalign_exc is high for one cycle.
  - Macro undefined: addr becomes 0x100 and misalign_exc stays 0.

Source files
------------

// File: rtl/fetch_pc_ctrl.sv
// Fetch-stage PC sequencer: next-PC selection, imem request handshake and IF/ID capture with a one-entry hold buffer.
// Optional feature: define FETCH_MISALIGN_TRAP_EN to trap misaligned redirect targets to TRAP_VEC.
module fetch_pc_ctrl #(
    parameter logic [31:0] RESET_VEC = 32'h0000_0000
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    parameter logic [31:0] TRAP_VEC  = 32'h0000_0080
`endif
) (
    input  logic        CLK,
    input  logic        RST_N,
    input  logic        stall,
    input  logic        br_taken,
    input  logic [31:0] br_target,
    input  logic        jmp_valid,
    input  logic [31:0] jmp_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    output logic        if_valid,
    output logic        flush_ifid,
    output logic        misalign_exc
);

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2,
        HOLD  = 2'd3
    } state_t;

    state_t      state;
    logic [31:0] pc;
    logic [31:0] redir_pc;
    logic [31:0] hold_buf;
    logic [31:0] hold_pc;

    logic        redirect;
    logic [31:0] raw_target;
    logic [31:0] target;

    function automatic logic [31:0] legalize_target(input logic [31:0] t);
`ifdef FETCH_MISALIGN_TRAP_EN
        return (t[1:0] != 2'b00) ? TRAP_VEC : t;
`else
        return t & 32'hFFFF_FFFC;
`endif
    endfunction

    // Branch resolves later in the pipe than jump, so it wins when both fire.
    assign redirect   = br_taken | jmp_valid;
    assign raw_target = br_taken ? br_target : jmp_target;
    assign target     = legalize_target(raw_target);
    assign flush_ifid = redirect;

    // DRAIN keeps the stale request up until the memory accepts it.
    assign imem_req  = (state == FETCH) || (state == DRAIN);
    assign imem_addr = pc;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            state    <= BOOT;
            pc       <= RESET_VEC;
            instr    <= '0;
            instr_pc <= '0;
            if_valid <= 1'b0;
        end else begin
            case (state)
                BOOT: begin
                    state <= FETCH;
                end
                FETCH: begin
                    if (redirect) begin
                        if_valid <= 1'b0;
                        if (imem_ack) begin
                            pc <= target;
                        end else begin
                            redir_pc <= target;
                            state    <= DRAIN;
                        end
                    end else if (imem_ack) begin
                        pc <= pc + 32'd4;
                        if (stall) begin
                            hold_buf <= imem_rdata;
                            hold_pc  <= pc;
                            state    <= HOLD;
                        end else begin
                            instr    <= imem_rdata;
                            instr_pc <= pc;
                            if_valid <= 1'b1;
                        end
                    end else if (!stall) begin
                        if_valid <= 1'b0;
                    end
                end
                DRAIN: begin
                    if_valid <= 1'b0;
                    // A redirect arriving with the ack supersedes the one already pending.
                    if (imem_ack) begin
                        pc    <= redirect ? target : redir_pc;
                        state <= FETCH;
                    end else if (redirect) begin
                        redir_pc <= target;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc       <= target;
                        if_valid <= 1'b0;
                        state    <= FETCH;
                    end else if (!stall) begin
                        instr    <= hold_buf;
                        instr_pc <= hold_pc;
                        if_valid <= 1'b1;
                        state    <= FETCH;
                    end
                end
                default: begin
                    state <= BOOT;
                end
            endcase
        end
    end

`ifdef FETCH_MISALIGN_TRAP_EN
    logic exc_q;

    always_ff @(posedge CLK) begin
        if (!RST_N) begin
            exc_q <= 1'b0;
        end else begin
            exc_q <= (state != BOOT) && redirect && (raw_target[1:0] != 2'b00);
        end
    end

    assign misalign_exc = exc_q;
`else
    assign misalign_exc = 1'b0;
`endif

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed bench for fetch_pc_ctrl with a per-cycle reference model and literal spot checks.
module tb_fetch_pc_ctrl;

    localparam logic [31:0] RESET_VEC = 32'h0000_0000;
    localparam logic [31:0] TRAP_VEC  = 32'h0000_0080;

    logic        CLK;
    logic        RST_N;
    logic        stall;
    logic        br_taken;
    logic [31:0] br_target;
    logic        jmp_valid;
    logic [31:0] jmp_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        if_valid;
    logic        flush_ifid;
    logic        misalign_exc;

    logic [31:0] key;
    int          checks = 0;
    int          errors = 0;
    bit          armed  = 0;

    // memory returns its address scrambled by a key so data and PC paths differ
    assign imem_rdata = imem_addr ^ key;

    fetch_pc_ctrl dut (
        .CLK          (CLK),
        .RST_N        (RST_N),
        .stall        (stall),
        .br_taken     (br_taken),
        .br_target    (br_target),
        .jmp_valid    (jmp_valid),
        .jmp_target   (jmp_target),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ack     (imem_ack),
        .imem_rdata   (imem_rdata),
        .instr        (instr),
        .instr_pc     (instr_pc),
        .if_valid     (if_valid),
        .flush_ifid   (flush_ifid),
        .misalign_exc (misalign_exc)
    );

    initial begin
        CLK = 1'b0;
        forever #5 CLK = ~CLK;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: flags for "booting", "draining a stale request", "holding a word".
    bit          m_boot, m_drain, m_hold, m_valid, m_exc;
    logic [31:0] m_pc, m_dpc, m_hw, m_hpc, m_instr, m_ipc;

    always @(posedge CLK) begin
        logic        redir, bad;
        logic [31:0] raw, tgt;
        if (!RST_N) begin
            m_boot = 1; m_drain = 0; m_hold = 0; m_valid = 0; m_exc = 0;
            m_pc = RESET_VEC; m_instr = 0; m_ipc = 0;
            armed = 1;
        end else begin
            redir = br_taken | jmp_valid;
            raw   = br_taken ? br_target : jmp_target;
`ifdef FETCH_MISALIGN_TRAP_EN
            bad = redir && (raw % 4 != 0);
            tgt = bad ? TRAP_VEC : raw;
`else
            bad = 0;
            tgt = raw - (raw % 4);
`endif
            m_exc = 0;
            if (m_boot) begin
                m_boot = 0;
            end else if (m_hold) begin
                if (redir) begin
                    m_pc = tgt; m_valid = 0; m_hold = 0; m_exc = bad;
                end else if (!stall) begin
                    m_instr = m_hw; m_ipc = m_hpc; m_valid = 1; m_hold = 0;
                end
            end else if (m_drain) begin
                m_valid = 0;
                if (redir) begin m_dpc = tgt; m_exc = bad; end
                if (imem_ack) begin m_pc = m_dpc; m_drain = 0; end
            end else begin
                if (redir) begin
                    m_valid = 0; m_exc = bad;
                    if (imem_ack) m_pc = tgt;
                    else begin m_dpc = tgt; m_drain = 1; end
                end else if (imem_ack) begin
                    if (stall) begin m_hw = imem_rdata; m_hpc = m_pc; m_hold = 1; end
                    else begin m_instr = imem_rdata; m_ipc = m_pc; m_valid = 1; end
                    m_pc = m_pc + 32'd4;
                end else if (!stall) begin
                    m_valid = 0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        if (armed) begin
            chk("m_imem_req",   {31'b0, imem_req},     {31'b0, !m_boot && !m_hold});
            chk("m_imem_addr",  imem_addr,             m_pc);
            chk("m_flush_ifid", {31'b0, flush_ifid},   {31'b0, br_taken | jmp_valid});
            chk("m_instr",      instr,                 m_instr);
            chk("m_instr_pc",   instr_pc,              m_ipc);
            chk("m_if_valid",   {31'b0, if_valid},     {31'b0, m_valid});
            chk("m_misalign",   {31'b0, misalign_exc}, {31'b0, m_exc});
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    initial begin
        RST_N = 0; stall = 0; br_taken = 0; br_target = 0;
        jmp_valid = 0; jmp_target = 0; imem_ack = 1; key = 0;
        repeat (3) tick();
        chk("rst_req",   {31'b0, imem_req}, 32'd0);
        chk("rst_addr",  imem_addr, 32'h0);
        chk("rst_valid", {31'b0, if_valid}, 32'd0);
        chk("rst_instr", instr, 32'h0);
        chk("rst_exc",   {31'b0, misalign_exc}, 32'd0);
        RST_N = 1;
        tick();
        chk("boot_req",  {31'b0, imem_req}, 32'd1);
        chk("boot_addr", imem_addr, 32'h0);
        tick();
        chk("seq_addr4", imem_addr, 32'h4);
        chk("seq_ipc0",  instr_pc, 32'h0);
        chk("seq_valid", {31'b0, if_valid}, 32'd1);
        tick();
        chk("seq_addr8", imem_addr, 32'h8);
        chk("seq_instr4", instr, 32'h4);
        // stall on the cycle address 8 is acked
        stall = 1;
        tick();
        chk("hold_req",   {31'b0, imem_req}, 32'd0);
        chk("hold_instr", instr, 32'h4);
        stall = 0;
        tick();
        chk("unhold_instr", instr, 32'h8);
        chk("unhold_addr",  imem_addr, 32'hC);
        tick();
        chk("resume_addr", imem_addr, 32'h10);
        // branch and jump together
        key = 32'hA5A5_0000;
        br_taken = 1; br_target = 32'h100; jmp_valid = 1; jmp_target = 32'h200;
        #1;
        chk("both_flush", {31'b0, flush_ifid}, 32'd1);
        tick();
        br_taken = 0; jmp_valid = 0;
        #1;
        chk("br_wins_addr", imem_addr, 32'h100);
        chk("br_flushed",   {31'b0, if_valid}, 32'd0);
        tick();
        chk("br_penalty_instr", instr, 32'hA5A5_0100);
        chk("br_penalty_ipc",   instr_pc, 32'h100);
        // redirect while the request at 0x20 is waiting
        jmp_valid = 1; jmp_target = 32'h20;
        tick();
        jmp_valid = 0; imem_ack = 0;
        tick();
        br_taken = 1; br_target = 32'h40;
        tick();
        br_taken = 0;
        #1;
        chk("drain_addr",  imem_addr, 32'h20);
        chk("drain_req",   {31'b0, imem_req}, 32'd1);
        chk("drain_valid", {31'b0, if_valid}, 32'd0);
        tick();
        chk("drain_addr2", imem_addr, 32'h20);
        imem_ack = 1;
        tick();
        chk("drain_next",    imem_addr, 32'h40);
        chk("drain_discard", {31'b0, if_valid}, 32'd0);
        tick();
        chk("drain_target_ipc", instr_pc, 32'h40);
        // wrap
        jmp_valid = 1; jmp_target = 32'hFFFF_FFFC;
        tick();
        jmp_valid = 0;
        #1;
        chk("wrap_top", imem_addr, 32'hFFFF_FFFC);
        tick();
        chk("wrap_zero", imem_addr, 32'h0);
        // misaligned jump
        jmp_valid = 1; jmp_target = 32'h102;
        tick();
        jmp_valid = 0;
        #1;
`ifdef FETCH_MISALIGN_TRAP_EN
        chk("mis_addr", imem_addr, 32'h80);
        chk("mis_exc",  {31'b0, misalign_exc}, 32'd1);
`else
        chk("mis_addr", imem_addr, 32'h100);
        chk("mis_exc",  {31'b0, misalign_exc}, 32'd0);
`endif
        tick();
        chk("mis_exc_end", {31'b0, misalign_exc}, 32'd0);
        // redirect out of HOLD
        stall = 1;
        tick();
        chk("hold2_req", {31'b0, imem_req}, 32'd0);
        br_taken = 1; br_target = 32'h300;
        tick();
        br_taken = 0; stall = 0;
        #1;
        chk("hold_redir_addr",  imem_addr, 32'h300);
        chk("hold_redir_valid", {31'b0, if_valid}, 32'd0);
        tick();
        imem_ack = 0; stall = 1;
        tick();
        chk("stall_keep_valid", {31'b0, if_valid}, 32'd1);
        stall = 0;
        tick();
        chk("nostall_drop_valid", {31'b0, if_valid}, 32'd0);
        // reset in the middle of a waiting request
        RST_N = 0;
        tick();
        chk("midrst_req",  {31'b0, imem_req}, 32'd0);
        chk("midrst_addr", imem_addr, 32'h0);
        RST_N = 1; imem_ack = 1;
        tick();
        chk("midrst_boot_req", {31'b0, imem_req}, 32'd1);
        // mixed traffic checked by the model alone
        for (int i = 0; i < 150; i++) begin
            stall      = (i % 5 == 3);
            imem_ack   = (i % 3 != 1);
            br_taken   = (i % 17 == 9);
            br_target  = 32'h400 + i * 8 + (i % 4);
            jmp_valid  = (i % 11 == 4) || (i % 13 == 6);
            jmp_target = 32'h800 + i * 4 + (i % 3);
            tick();
        end
        stall = 0; br_taken = 0; jmp_valid = 0; imem_ack = 1;
        repeat (3) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
